mdu_div_issuer: RTL and testbench
=================================

MDU_DIV_ISSUER -- requirements
Module: mdu_div_issuer

Interface
REQ-001 Parameter DEPTH, 4, dispatch FIFO entries; power of two, at least 2.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 flush  in  1  synchronous pipeline flush.
REQ-005 in_valid_i  in  1  dispatch offers a divide/modulo op.
REQ-006 in_op_i  in  3  op code (`_MDU_DIV, `_MDU_DIVU, `_MDU_MOD, `_MDU_MODU).
REQ-007 in_data0_i / in_data1_i  in  32 each  dividend / divisor.
REQ-008 in_rob_id_i  in  `ROB_WIDTH  destination ROB tag.
REQ-009 in_ready_o  out  1  FIFO can accept.
REQ-010 req_valid_o, req_op_o[3], req_data0_o[32], req_data1_o[32], req_reg_addr_o[`ROB_WIDTH]  out  request to divider.
REQ-011 req_ready_i  in  1  divider accepts request.
REQ-012 resp_valid_i  in  1; resp_result_i  in  32; resp_reg_addr_i  in  `ROB_WIDTH  divider result.
REQ-013 resp_ready_o  out  1  issuer accepts result.
REQ-014 wb_valid_o  out  1; wb_rob_id_o  out  `ROB_WIDTH; wb_data_o  out  32  writeback to ROB.
REQ-015 wb_ready_i  in  1  writeback consumer accepts.
REQ-016 count_o  out  $clog2(DEPTH)+1  FIFO occupancy; err_o  out  1  sticky tag-mismatch flag.

Function
REQ-017 FIFO: push on in_valid_i & in_ready_o; pop on req_valid_o & req_ready_i; in_ready_o = (count < DEPTH) & ~flush.
REQ-018 Pointers wrap modulo DEPTH; simultaneous push and pop leaves count unchanged; push while full impossible (in_ready_o low, no same-cycle pop bypass).
REQ-019 req_* fields driven from FIFO head; req_valid_o = ~empty & ~inflight & ~flush.
REQ-020 At most one op in flight: inflight sets on request handshake (capturing head rob tag into tag_q), clears on response handshake.
REQ-021 Minimum latency: op accepted at cycle N drives req_valid_o at N+1; next op cannot issue before the cycle after the previous response handshake.
REQ-022 resp_ready_o = ~wb_valid_o | wb_ready_i | flush.
REQ-023 Response handshake with inflight=1: load wb_valid_o=1, wb_rob_id_o=tag_q, wb_data_o=resp_result_i on next edge.
REQ-024 If resp_reg_addr_i differs from tag_q at a response handshake, err_o sets and stays set until reset; writeback still uses tag_q.
REQ-025 Response handshake with inflight=0 (stale post-flush result): discarded, no writeback, err_o unchanged.
REQ-026 wb_valid_o clears on wb_ready_i handshake unless a new response loads the same cycle (back-to-back writeback allowed).
REQ-027 wb_* held stable while wb_valid_o=1 and wb_ready_i=0; req_* held stable while req_valid_o=1 and req_ready_i=0.
REQ-028 flush: next edge clears FIFO pointers, count, inflight, wb_valid_o; in-cycle pushes and responses are dropped; err_o unaffected.
REQ-029 Op codes and data pass through unmodified; no arithmetic in this block.

Reset
REQ-030 While rst high: count_o=0, inflight=0, wb_valid_o=0, err_o=0, req_valid_o=0, pointers=0; in_ready_o=0 during reset, 1 first cycle after.
REQ-031 Reset mid-operation discards all queued, in-flight and pending writeback ops with no writeback.

Verification
REQ-032 Single op DIV 100/7 rob 5, req_ready_i=1, divider returns 14 tag 5 -> wb_valid_o one cycle after response, wb_rob_id_o=5, wb_data_o=14, err_o=0.
REQ-033 Push 5 ops with DEPTH=4 and req_ready_i=0 -> count_o reaches 4, in_ready_o=0, fifth held; raise req_ready_i -> ops issue in order, one per response.
REQ-034 wb_ready_i=0 with wb_valid_o=1 and second result pending -> resp_ready_o=0, wb_* stable; release -> both writebacks in order, no loss.
REQ-035 flush with 3 queued and 1 in flight -> next cycle count_o=0, wb_valid_o=0; late response with resp_valid_i=1 discarded, no wb_valid_o.
REQ-036 Response tag 6 against tag_q 3 -> err_o=1 sticky, writeback carries rob 3; err_o clears only on rst.

Source files
------------

// File: rtl/mdu_div_issuer.sv
// Divide/modulo issuer: DEPTH-entry dispatch FIFO, one op in flight, one-entry writeback register.
// Latency: accept at N -> request at N+1, writeback one edge after the response; each stage stalls on its ready.
`ifndef ROB_WIDTH
`define ROB_WIDTH 5
`endif
`ifndef _MDU_DIV
`define _MDU_DIV  3'b100
`define _MDU_DIVU 3'b101
`define _MDU_MOD  3'b110
`define _MDU_MODU 3'b111
`endif

module mdu_div_issuer #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid_i,
    input  logic [2:0]              in_op_i,
    input  logic [31:0]             in_data0_i,
    input  logic [31:0]             in_data1_i,
    input  logic [`ROB_WIDTH-1:0]   in_rob_id_i,
    output logic                    in_ready_o,
    output logic                    req_valid_o,
    output logic [2:0]              req_op_o,
    output logic [31:0]             req_data0_o,
    output logic [31:0]             req_data1_o,
    output logic [`ROB_WIDTH-1:0]   req_reg_addr_o,
    input  logic                    req_ready_i,
    input  logic                    resp_valid_i,
    input  logic [31:0]             resp_result_i,
    input  logic [`ROB_WIDTH-1:0]   resp_reg_addr_i,
    output logic                    resp_ready_o,
    output logic                    wb_valid_o,
    output logic [`ROB_WIDTH-1:0]   wb_rob_id_o,
    output logic [31:0]             wb_data_o,
    input  logic                    wb_ready_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = `ROB_WIDTH;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [2:0]    r_op_mem  [DEPTH];
    logic [31:0]   r_d0_mem  [DEPTH];
    logic [31:0]   r_d1_mem  [DEPTH];
    logic [RW-1:0] r_tag_mem [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_inflight;
    logic [RW-1:0] r_tag_q;
    logic          r_wb_valid;
    logic [RW-1:0] r_wb_rob;
    logic [31:0]   r_wb_data;
    logic          r_err;

    logic w_push;
    logic w_pop;
    logic w_resp_hs;

    assign in_ready_o   = ~rst & (r_count < FULL_CNT) & ~flush;
    assign req_valid_o  = (r_count != '0) & ~r_inflight & ~flush;
    assign resp_ready_o = ~r_wb_valid | wb_ready_i | flush;

    assign w_push    = in_valid_i & in_ready_o;
    assign w_pop     = req_valid_o & req_ready_i;
    assign w_resp_hs = resp_valid_i & resp_ready_o;

    assign req_op_o       = r_op_mem[r_rd_ptr];
    assign req_data0_o    = r_d0_mem[r_rd_ptr];
    assign req_data1_o    = r_d1_mem[r_rd_ptr];
    assign req_reg_addr_o = r_tag_mem[r_rd_ptr];

    assign wb_valid_o  = r_wb_valid;
    assign wb_rob_id_o = r_wb_rob;
    assign wb_data_o   = r_wb_data;
    assign count_o     = r_count;
    assign err_o       = r_err;

    // Payload storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr]  <= in_op_i;
            r_d0_mem[r_wr_ptr]  <= in_data0_i;
            r_d1_mem[r_wr_ptr]  <= in_data1_i;
            r_tag_mem[r_wr_ptr] <= in_rob_id_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_tag_q    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rob   <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_wb_valid <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase

            // Issue needs ~inflight and retire needs inflight, so they never coincide.
            if (w_pop) begin
                r_inflight <= 1'b1;
                r_tag_q    <= req_reg_addr_o;
            end else if (w_resp_hs && r_inflight) begin
                r_inflight <= 1'b0;
            end

            if (w_resp_hs && r_inflight) begin
                r_wb_valid <= 1'b1;
                r_wb_rob   <= r_tag_q;
                r_wb_data  <= resp_result_i;
                if (resp_reg_addr_i != r_tag_q) r_err <= 1'b1;
            end else if (r_wb_valid && wb_ready_i) begin
                r_wb_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mdu_div_issuer.sv
// Randomized bench for mdu_div_issuer: queue-based reference model plus a behavioural divider.
`ifndef ROB_WIDTH
`define ROB_WIDTH 5
`endif
`ifndef _MDU_DIV
`define _MDU_DIV  3'b100
`define _MDU_DIVU 3'b101
`define _MDU_MOD  3'b110
`define _MDU_MODU 3'b111
`endif

module tb_mdu_div_issuer;
    localparam int DEPTH = 4;
    localparam int RW    = `ROB_WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid_i = 1'b0;
    logic [2:0]    in_op_i = '0;
    logic [31:0]   in_data0_i = '0, in_data1_i = '0;
    logic [RW-1:0] in_rob_id_i = '0;
    logic          in_ready_o, req_valid_o;
    logic [2:0]    req_op_o;
    logic [31:0]   req_data0_o, req_data1_o;
    logic [RW-1:0] req_reg_addr_o;
    logic          req_ready_i = 1'b0;
    logic          resp_valid_i = 1'b0;
    logic [31:0]   resp_result_i = '0;
    logic [RW-1:0] resp_reg_addr_i = '0;
    logic          resp_ready_o, wb_valid_o;
    logic [RW-1:0] wb_rob_id_o;
    logic [31:0]   wb_data_o;
    logic          wb_ready_i = 1'b0;
    logic [2:0]    count_o;
    logic          err_o;

    always #5 clk = ~clk;

    mdu_div_issuer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid_i(in_valid_i), .in_op_i(in_op_i), .in_data0_i(in_data0_i),
        .in_data1_i(in_data1_i), .in_rob_id_i(in_rob_id_i), .in_ready_o(in_ready_o),
        .req_valid_o(req_valid_o), .req_op_o(req_op_o), .req_data0_o(req_data0_o),
        .req_data1_o(req_data1_o), .req_reg_addr_o(req_reg_addr_o), .req_ready_i(req_ready_i),
        .resp_valid_i(resp_valid_i), .resp_result_i(resp_result_i),
        .resp_reg_addr_i(resp_reg_addr_i), .resp_ready_o(resp_ready_o),
        .wb_valid_o(wb_valid_o), .wb_rob_id_o(wb_rob_id_o), .wb_data_o(wb_data_o),
        .wb_ready_i(wb_ready_i), .count_o(count_o), .err_o(err_o)
    );

    typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [RW-1:0] tag; } op_t;
    typedef struct { logic [RW-1:0] tag; logic [31:0] data; } wb_t;

    op_t           fq[$];
    wb_t           wq[$];
    bit            m_inf, m_err;
    logic [RW-1:0] m_tag;
    bit            dv_busy, cur_bad;
    int            dv_cnt;
    logic [31:0]   dv_res;
    logic [RW-1:0] dv_tag;
    wb_t           last_wb;
    int            wb_cnt;
    int            n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] div_ref(input op_t o);
        logic [31:0] r;
        bit ovf = (o.a == 32'h8000_0000) && (o.b == 32'hFFFF_FFFF);
        case (o.op)
            `_MDU_DIV:  r = (o.b == 0) ? 32'hFFFF_FFFF : ovf ? o.a : 32'($signed(o.a) / $signed(o.b));
            `_MDU_DIVU: r = (o.b == 0) ? 32'hFFFF_FFFF : o.a / o.b;
            `_MDU_MOD:  r = (o.b == 0) ? o.a : ovf ? 32'd0 : 32'($signed(o.a) % $signed(o.b));
            default:    r = (o.b == 0) ? o.a : o.a % o.b;
        endcase
        return r;
    endfunction

    task automatic step_begin(input int p_in, input int p_rr, input int p_wr, input int p_fl, input int p_bad);
        @(negedge clk);
        in_valid_i      = ($urandom_range(99) < p_in);
        in_op_i         = 3'b100 + 3'($urandom_range(3));
        in_data0_i      = $urandom;
        in_data1_i      = ($urandom_range(3) == 0) ? 32'($urandom_range(3)) : $urandom;
        in_rob_id_i     = RW'($urandom);
        req_ready_i     = !dv_busy && ($urandom_range(99) < p_rr);
        resp_valid_i    = dv_busy && (dv_cnt == 0);
        resp_result_i   = dv_res;
        resp_reg_addr_i = dv_tag;
        wb_ready_i      = ($urandom_range(99) < p_wr);
        flush           = ($urandom_range(99) < p_fl);
        cur_bad         = ($urandom_range(99) < p_bad);
    endtask

    task automatic eval();
        bit   e_in_rdy, e_req_v, e_resp_rdy, push, pop, rsp, wbh;
        op_t  ni;
        #1;
        e_in_rdy   = (fq.size() < DEPTH) && !flush;
        e_req_v    = (fq.size() != 0) && !m_inf && !flush;
        e_resp_rdy = (wq.size() == 0) || wb_ready_i || flush;
        chk("in_ready",   96'(in_ready_o),   96'(e_in_rdy));
        chk("req_valid",  96'(req_valid_o),  96'(e_req_v));
        chk("resp_ready", 96'(resp_ready_o), 96'(e_resp_rdy));
        chk("count",      96'(count_o),      96'(fq.size()));
        chk("wb_valid",   96'(wb_valid_o),   96'(wq.size() != 0));
        chk("err",        96'(err_o),        96'(m_err));
        if (e_req_v)
            chk("req_fields", 96'({req_op_o, req_data0_o, req_data1_o, req_reg_addr_o}),
                96'({fq[0].op, fq[0].a, fq[0].b, fq[0].tag}));
        if (wq.size() != 0)
            chk("wb_fields", 96'({wb_rob_id_o, wb_data_o}), 96'({wq[0].tag, wq[0].data}));

        push = in_valid_i && e_in_rdy;
        pop  = e_req_v && req_ready_i;
        rsp  = resp_valid_i && e_resp_rdy;
        wbh  = (wq.size() != 0) && wb_ready_i;

        if (rsp) dv_busy = 0;
        else if (dv_busy && dv_cnt > 0) dv_cnt--;
        if (pop) begin
            dv_busy = 1;
            dv_cnt  = $urandom_range(3);
            dv_res  = div_ref(fq[0]);
            dv_tag  = cur_bad ? (fq[0].tag ^ RW'(5)) : fq[0].tag;
        end

        if (flush) begin
            fq.delete();
            wq.delete();
            m_inf = 0;
        end else begin
            if (wbh) begin
                last_wb = wq[0];
                wb_cnt++;
                void'(wq.pop_front());
            end
            if (rsp && m_inf) begin
                if (resp_reg_addr_i != m_tag) m_err = 1;
                wq.push_back('{m_tag, resp_result_i});
                m_inf = 0;
            end
            if (pop) begin
                m_inf = 1;
                m_tag = fq[0].tag;
                void'(fq.pop_front());
            end
            if (push) begin
                ni = '{in_op_i, in_data0_i, in_data1_i, in_rob_id_i};
                fq.push_back(ni);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; flush = 0; in_valid_i = 0; req_ready_i = 0; resp_valid_i = 0; wb_ready_i = 0;
        #1;
        chk("rst_count",     96'(count_o),     96'(0));
        chk("rst_in_ready",  96'(in_ready_o),  96'(0));
        chk("rst_req_valid", 96'(req_valid_o), 96'(0));
        chk("rst_wb_valid",  96'(wb_valid_o),  96'(0));
        chk("rst_err",       96'(err_o),       96'(0));
        fq.delete(); wq.delete();
        m_inf = 0; m_err = 0; dv_busy = 0; dv_cnt = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_release_in_ready", 96'(in_ready_o), 96'(1));
    endtask

    task automatic run_until_wb(input int p_bad);
        wb_cnt = 0;
        for (int i = 0; i < 20 && wb_cnt == 0; i++) begin
            step_begin(0, 100, 100, 0, p_bad);
            eval();
        end
    endtask

    initial begin
        last_wb = '{'0, '0};
        do_reset();

        // Single DIV 100/7 tagged 5 must write back 14 to rob 5.
        step_begin(0, 100, 100, 0, 0);
        in_valid_i = 1; in_op_i = `_MDU_DIV; in_data0_i = 32'd100; in_data1_i = 32'd7; in_rob_id_i = 5;
        eval();
        run_until_wb(0);
        chk("single_div_wb", 96'({last_wb.tag, last_wb.data}), 96'({RW'(5), 32'd14}));
        chk("single_div_err", 96'(err_o), 96'(0));

        // Returned tag 6 against tag 3: writeback keeps rob 3, error becomes sticky.
        step_begin(0, 100, 100, 0, 100);
        in_valid_i = 1; in_op_i = `_MDU_DIVU; in_data0_i = 32'd50; in_data1_i = 32'd5; in_rob_id_i = 3;
        eval();
        run_until_wb(100);
        chk("bad_tag_wb_rob", 96'({last_wb.tag, last_wb.data}), 96'({RW'(3), 32'd10}));
        chk("bad_tag_err", 96'(err_o), 96'(1));
        repeat (100) begin step_begin(60, 70, 70, 3, 0); eval(); end
        chk("err_sticky", 96'(err_o), 96'(1));
        do_reset();

        repeat (300) begin step_begin(70, 15, 80, 0, 0); eval(); end
        repeat (300) begin step_begin(60, 80, 25, 0, 0); eval(); end
        repeat (400) begin step_begin(60, 70, 70, 5, 0); eval(); end
        repeat (300) begin step_begin(60, 70, 60, 2, 10); eval(); end
        do_reset();
        repeat (300) begin step_begin(50, 60, 60, 2, 3); eval(); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
